wb_stage_pipe: RTL
==================

Name: wb_stage_pipe

Overview:
Registered write-back stage for the MIPS pipeline, and the parametrised successor to the combinational WB muxing.
- Holds the MEM/WB pipeline register, with stall, flush and valid tracking.
- Selects among four write-back sources and sign/zero-extends sub-word loads.
- Drives the register-file write port and a sticky halt flag to the debug unit.

Parameters:
DATA_WIDTH, 32, datapath width (multiple of 16)
REG_ADDR_WIDTH, 5, register-file address width
CNT_WIDTH, 32, width of retire counter (optional feature only)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_stall  in  1  hold MEM/WB register contents
i_flush  in  1  invalidate incoming instruction
i_valid  in  1  MEM stage presents a real instruction
i_regwrite  in  1  instruction writes a register
i_rd  in  REG_ADDR_WIDTH  destination register
i_wb_sel  in  2  source: 00 ALU, 01 MEM, 10 return address, 11 immediate
i_alu_result  in  DATA_WIDTH  ALU result / memory address
i_dataread  in  DATA_WIDTH  raw word read from data memory
i_return_address  in  DATA_WIDTH  PC+8 for JAL/JALR
i_imm  in  DATA_WIDTH  pre-shifted immediate (LUI)
i_ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend
i_halt  in  1  instruction is HALT
o_valid  out  1  registered valid
o_wr_en  out  1  register-file write enable
o_wr_addr  out  REG_ADDR_WIDTH  register-file write address
o_wr_data  out  DATA_WIDTH  register-file write data
o_halted  out  1  sticky halt reached

Behaviour:
- Clock and reset: single clock i_clk. i_reset is synchronous and active-high; all state updates on the rising edge of i_clk.
- Reset values:
  - o_valid=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_halted=0.
  - All internal pipeline fields are cleared.
- Register update priority per edge: i_reset > i_flush > i_stall > load.
  - Flush: valid bit <= 0. Other fields may load, but have no effect while valid=0.
  - Stall without flush: every field is held.
  - Load: all inputs are captured; valid <= i_valid.
- Latency: one cycle. Inputs sampled at edge N drive o_wr_* during cycle N+1.
- o_wr_en = valid & regwrite & (rd != 0). Writes to $zero are never issued.
- o_wr_addr = registered rd. o_wr_data is combinational from registered fields only; no input-to-output combinational path.
- Load extension (wb_sel=01), lane = registered alu_result[1:0]:
  - byte: lane selects byte 0..3 (little-endian).
  - half: lane[1] selects halfword; lane[0] is ignored (alignment is an EX responsibility).
  - word / reserved: raw data, no extension.
  - Sign bit is the MSB of the selected lane; i_ld_unsigned forces zero fill.
- Halt:
  - o_halted sets on the cycle the registered instruction is valid & halt.
  - It stays set until reset; flush and stall do not clear it.
  - A halt with regwrite=1 still writes.
- Stall while valid: o_wr_en stays asserted with the same data. The register file tolerates repeated identical writes.
- Reset asserted mid-stream: the next cycle shows o_valid=0 and o_wr_en=0, regardless of stall or flush.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined:
  - Adds output o_retired [CNT_WIDTH].
  - The counter increments by 1 each cycle that valid=1 and the stage is not stalled, i.e. the register advances. The increment happens on the edge that retires the instruction.
  - Wraps at 2^CNT_WIDTH to 0.
  - Reset to 0; freezes once o_halted=1.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package wb_pkg: wb_sel encodings (WB_SEL_ALU/MEM/RET/IMM) and ld_size encodings (LD_BYTE/HALF/WORD).
- Sub-module wb_load_ext: purely combinational lane select plus extension, parametrised by DATA_WIDTH.
- The pipeline register and the source mux stay in wb_stage_pipe.

Test Plan:
- Reset then idle: after reset, o_valid=0, o_wr_en=0, o_halted=0, o_wr_data=0.
- LB signed: i_dataread=0x1234_80FF, addr[1:0]=1, size=byte, unsigned=0, rd=3, sel=01 → next cycle o_wr_en=1, o_wr_addr=3, o_wr_data=0xFFFF_FF80. Same with unsigned=1 → 0x0000_0080.
- LH lane 1 signed: data=0x8001_7FFF, addr[1:0]=2 → 0xFFFF_8001. Source sweep, one per cycle: sel=00 alu=0xA5 → 0xA5; sel=10 ret=0x0040_0008 → 0x0040_0008; sel=11 imm=0x1234_0000 → 0x1234_0000.
- Write to $zero: rd=0, regwrite=1, valid=1 → o_wr_en=0 while o_valid=1.
- Stall/flush interplay: load rd=5; stall 3 cycles with changing inputs → o_wr_addr stays 5 and data is unchanged. Then assert flush+stall together → o_valid=0 next cycle.
- Halt: valid halt instruction → o_halted=1 next cycle; subsequent flushes leave it at 1; i_reset clears it. With WB_RETIRE_CNT_EN: 4 valid unstalled instructions then halt → o_retired=5 and stays 5.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the MIPS write-back stage: source select and load size.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_RET = 2'b10,
        WB_SEL_IMM = 2'b11
    } wb_sel_e;

    // 2'b11 is reserved and handled like a full word
    typedef enum logic [1:0] {
        LD_BYTE = 2'b00,
        LD_HALF = 2'b01,
        LD_WORD = 2'b10
    } ld_size_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational sub-word lane select and sign/zero extension for loads.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_lane,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] byte_shifted;
    logic [DATA_WIDTH-1:0] half_shifted;
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic                  byte_sign;
    logic                  half_sign;

    // Shifting rather than indexing keeps narrow datapaths elaborating cleanly.
    assign byte_shifted = i_data >> {i_lane, 3'b000};
    assign half_shifted = i_data >> {i_lane[1], 4'b0000};
    assign byte_val     = byte_shifted[7:0];
    assign half_val     = half_shifted[15:0];
    assign byte_sign    = byte_val[7] & ~i_unsigned;
    assign half_sign    = half_val[15] & ~i_unsigned;

    always_comb begin
        o_data = i_data;
        case (i_size)
            LD_BYTE: o_data = {{(DATA_WIDTH-8){byte_sign}}, byte_val};
            LD_HALF: o_data = {{(DATA_WIDTH-16){half_sign}}, half_val};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered MEM/WB stage: pipeline register, write-back source mux, sticky halt.
// Define WB_RETIRE_CNT_EN to add the o_retired instruction retire counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
`ifdef WB_RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH      = 32
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic                      i_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic [1:0]                i_wb_sel,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_dataread,
    input  logic [DATA_WIDTH-1:0]     i_return_address,
    input  logic [DATA_WIDTH-1:0]     i_imm,
    input  logic [1:0]                i_ld_size,
    input  logic                      i_ld_unsigned,
    input  logic                      i_halt,
    output logic                      o_valid,
    output logic                      o_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]     o_wr_data,
    output logic                      o_halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      o_retired
`endif
);

    logic                      valid_q;
    logic                      regwrite_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [1:0]                wb_sel_q;
    logic [DATA_WIDTH-1:0]     alu_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     ret_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [1:0]                ld_size_q;
    logic                      ld_unsigned_q;
    logic                      halt_q;
    logic                      halt_sticky;
    logic [DATA_WIDTH-1:0]     load_data;

    // A flush only needs to clear valid; payload fields load as usual.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q       <= 1'b0;
            regwrite_q    <= 1'b0;
            rd_q          <= '0;
            wb_sel_q      <= '0;
            alu_q         <= '0;
            data_q        <= '0;
            ret_q         <= '0;
            imm_q         <= '0;
            ld_size_q     <= '0;
            ld_unsigned_q <= 1'b0;
            halt_q        <= 1'b0;
            halt_sticky   <= 1'b0;
        end else begin
            if (i_flush) begin
                valid_q <= 1'b0;
            end else if (!i_stall) begin
                valid_q <= i_valid;
            end
            if (i_flush || !i_stall) begin
                regwrite_q    <= i_regwrite;
                rd_q          <= i_rd;
                wb_sel_q      <= i_wb_sel;
                alu_q         <= i_alu_result;
                data_q        <= i_dataread;
                ret_q         <= i_return_address;
                imm_q         <= i_imm;
                ld_size_q     <= i_ld_size;
                ld_unsigned_q <= i_ld_unsigned;
                halt_q        <= i_halt;
            end
            halt_sticky <= halt_sticky | (valid_q & halt_q);
        end
    end

    wb_load_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_ext (
        .i_data     (data_q),
        .i_lane     (alu_q[1:0]),
        .i_size     (ld_size_q),
        .i_unsigned (ld_unsigned_q),
        .o_data     (load_data)
    );

    always_comb begin
        o_wr_data = alu_q;
        case (wb_sel_q)
            WB_SEL_ALU: o_wr_data = alu_q;
            WB_SEL_MEM: o_wr_data = load_data;
            WB_SEL_RET: o_wr_data = ret_q;
            WB_SEL_IMM: o_wr_data = imm_q;
            default:    o_wr_data = alu_q;
        endcase
    end

    assign o_valid   = valid_q;
    assign o_wr_en   = valid_q & regwrite_q & (rd_q != '0);
    assign o_wr_addr = rd_q;
    assign o_halted  = halt_sticky | (valid_q & halt_q);

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] retired_q;

    // The halting instruction itself retires before the count freezes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            retired_q <= '0;
        end else if (!halt_sticky && valid_q && !i_stall) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign o_retired = retired_q;
`endif

endmodule
